// File: rtl/gate_pkg.sv
// Shared types for the parking-gate barrier scheduler.
package gate_pkg;

    typedef enum logic [1:0] {
        DOWN       = 2'b00,
        UP_START   = 2'b01,
        UP         = 2'b10,
        DOWN_START = 2'b11
    } bar_cmd_t;

    typedef enum logic [1:0] {
        IDLE,
        RAISE,
        OPEN,
        LOWER
    } gate_state_t;

    typedef enum logic {
        ENTRY,
        EXIT
    } dir_t;

    // Barrier command driven while the scheduler sits in a given state
    function automatic bar_cmd_t state_cmd(input gate_state_t s);
        case (s)
            IDLE:    return DOWN;
            RAISE:   return UP_START;
            OPEN:    return UP;
            LOWER:   return DOWN_START;
            default: return DOWN;
        endcase
    endfunction

endpackage

// File: rtl/gate_timer.sv
// Loadable down-counter shared by the travel and pass-timeout phases.
module gate_timer #(
    parameter int unsigned W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] value,
    output logic         done
);

    logic [W-1:0] count;
    logic [W-1:0] count_next;

    always_comb begin
        count_next = count;
        if (load) begin
            count_next = value;
        end else if (count != '0) begin
            count_next = count - W'(1);
        end
    end

    // done is high in the cycle the counter sits at zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
            done  <= 1'b0;
        end else begin
            count <= count_next;
            done  <= (count_next == '0);
        end
    end

endmodule

// File: rtl/gate_scheduler.sv
// Barrier scheduler: arbitrates entry/exit lanes, sequences the barrier, tracks occupancy.
// Optional safety reversal in LOWER enabled by defining GATE_SAFETY_REVERSE_EN.
module gate_scheduler
    import gate_pkg::*;
#(
    parameter int unsigned CAPACITY     = 8,
    parameter int unsigned TRAVEL_CYC   = 4,
    parameter int unsigned PASS_TIMEOUT = 16
) (
    input  logic                             clk,
    input  logic                             R,
    input  logic                             entry_req,
    input  logic                             exit_req,
    input  logic                             C,
    output logic                             entry_gnt,
    output logic                             exit_gnt,
    output logic [1:0]                       bar_cmd,
    output logic [$clog2(CAPACITY+1)-1:0]    occupancy,
    output logic                             full,
    output logic                             busy
);

    localparam int unsigned OCC_W  = $clog2(CAPACITY + 1);
    localparam int unsigned T_MAX  = (TRAVEL_CYC > PASS_TIMEOUT) ? TRAVEL_CYC : PASS_TIMEOUT;
    localparam int unsigned TMR_W  = $clog2(T_MAX + 1);
    localparam logic [TMR_W-1:0] TRAVEL_LD = TMR_W'(TRAVEL_CYC - 1);
    localparam logic [TMR_W-1:0] PASS_LD   = TMR_W'(PASS_TIMEOUT - 1);
    localparam logic [OCC_W-1:0] OCC_MAX   = OCC_W'(CAPACITY);

    gate_state_t      state, state_next;
    dir_t             dir, dir_next;
    dir_t             last, last_next;
    logic             seen, seen_next;
    logic             c_q;
    logic [OCC_W-1:0] occ_next;
    logic             tmr_load;
    logic [TMR_W-1:0] tmr_val;
    logic             tmr_done;
    logic             entry_gnt_next, exit_gnt_next;
    logic             elig_entry, elig_exit, win_exit;

    assign elig_entry = entry_req && !full;
    assign elig_exit  = exit_req && (occupancy != '0);
    // With both lanes eligible, the lane not served last wins
    assign win_exit   = elig_exit && (!elig_entry || (last == ENTRY));

    gate_timer #(.W(TMR_W)) u_timer (
        .clk   (clk),
        .rst_n (R),
        .load  (tmr_load),
        .value (tmr_val),
        .done  (tmr_done)
    );

    always_comb begin
        state_next     = state;
        dir_next       = dir;
        last_next      = last;
        seen_next      = seen;
        occ_next       = occupancy;
        tmr_load       = 1'b0;
        tmr_val        = TRAVEL_LD;
        entry_gnt_next = 1'b0;
        exit_gnt_next  = 1'b0;

        case (state)
            IDLE: begin
                if (elig_entry || elig_exit) begin
                    dir_next       = win_exit ? EXIT : ENTRY;
                    last_next      = win_exit ? EXIT : ENTRY;
                    seen_next      = 1'b0;
                    state_next     = RAISE;
                    tmr_load       = 1'b1;
                    tmr_val        = TRAVEL_LD;
                    entry_gnt_next = !win_exit;
                    exit_gnt_next  = win_exit;
                end
            end
            RAISE: begin
                if (tmr_done) begin
                    state_next = OPEN;
                    tmr_load   = 1'b1;
                    tmr_val    = PASS_LD;
                end
            end
            OPEN: begin
                if (!seen && C) begin
                    seen_next = 1'b1;
                end
                if (seen && c_q && !C) begin
                    state_next = LOWER;
                    tmr_load   = 1'b1;
                    tmr_val    = TRAVEL_LD;
                    if (dir == ENTRY) begin
                        occ_next = (occupancy == OCC_MAX) ? occupancy : occupancy + OCC_W'(1);
                    end else begin
                        occ_next = (occupancy == '0) ? occupancy : occupancy - OCC_W'(1);
                    end
                end else if (!seen && !C && tmr_done) begin
                    state_next = LOWER;
                    tmr_load   = 1'b1;
                    tmr_val    = TRAVEL_LD;
                end
            end
            LOWER: begin
`ifdef GATE_SAFETY_REVERSE_EN
                if (C) begin
                    state_next = RAISE;
                    tmr_load   = 1'b1;
                    tmr_val    = TRAVEL_LD;
                end else if (tmr_done) begin
                    state_next = IDLE;
                end
`else
                if (tmr_done) begin
                    state_next = IDLE;
                end
`endif
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State and registered outputs; reset favours exit on the first tie
    always_ff @(posedge clk or negedge R) begin
        if (!R) begin
            state     <= IDLE;
            dir       <= ENTRY;
            last      <= ENTRY;
            seen      <= 1'b0;
            c_q       <= 1'b0;
            occupancy <= '0;
            full      <= 1'b0;
            busy      <= 1'b0;
            bar_cmd   <= DOWN;
            entry_gnt <= 1'b0;
            exit_gnt  <= 1'b0;
        end else begin
            state     <= state_next;
            dir       <= dir_next;
            last      <= last_next;
            seen      <= seen_next;
            c_q       <= C;
            occupancy <= occ_next;
            full      <= (occ_next == OCC_MAX);
            busy      <= (state_next != IDLE);
            bar_cmd   <= state_cmd(state_next);
            entry_gnt <= entry_gnt_next;
            exit_gnt  <= exit_gnt_next;
        end
    end

endmodule

// File: tb/tb_gate_scheduler.sv
// Self-checking bench for gate_scheduler: vector table, corner sequences, random transactions.
module tb_gate_scheduler;

    localparam int CAP   = 8;
    localparam int TRV   = 4;
    localparam int PT    = 16;
    localparam int OCC_W = $clog2(CAP + 1);

    logic             clk = 1'b0;
    logic             R;
    logic             entry_req, exit_req, C;
    logic             entry_gnt, exit_gnt, full, busy;
    logic [1:0]       bar_cmd;
    logic [OCC_W-1:0] occupancy;

    int n_cmp = 0;
    int n_bad = 0;
    int m_occ = 0;   // model occupancy
    int m_last = 1;  // last served lane: 1 entry, 2 exit (reset favours exit)

    gate_scheduler #(.CAPACITY(CAP), .TRAVEL_CYC(TRV), .PASS_TIMEOUT(PT)) dut (
        .clk       (clk),
        .R         (R),
        .entry_req (entry_req),
        .exit_req  (exit_req),
        .C         (C),
        .entry_gnt (entry_gnt),
        .exit_gnt  (exit_gnt),
        .bar_cmd   (bar_cmd),
        .occupancy (occupancy),
        .full      (full),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic er;
        logic xr;
        int   k;    // OPEN cycles before the vehicle arrives (>= PT means none)
        int   m;    // cycles the vehicle stays under the barrier
        int   win;  // 0 none, 1 entry, 2 exit
        int   occ;  // occupancy after the transaction
    } vec_t;

    vec_t tbl[10];

    task automatic tick(input logic er, input logic xr, input logic c);
        entry_req = er;
        exit_req  = xr;
        C         = c;
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic junk();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic chk(input string name, input logic [1:0] cmd, input logic eg,
                       input logic xg, input int occ);
        logic ef, eb;
        ef = (occ == CAP);
        eb = (cmd != 2'b00);
        n_cmp++;
        if (bar_cmd !== cmd || entry_gnt !== eg || exit_gnt !== xg ||
            occupancy !== OCC_W'(occ) || full !== ef || busy !== eb) begin
            n_bad++;
            $display("FAIL %s: got cmd=%b eg=%b xg=%b occ=%0d full=%b busy=%b, want cmd=%b eg=%b xg=%b occ=%0d full=%b busy=%b",
                     name, bar_cmd, entry_gnt, exit_gnt, occupancy, full, busy,
                     cmd, eg, xg, occ, ef, eb);
        end
    endtask

    // One full request-to-IDLE transaction, checked every cycle against the expected schedule
    task automatic txn(input logic er, input logic xr, input int k, input int m,
                       input int win, input int occ_after, input string tag);
        int  open_len;
        logic c;
        tick(er, xr, 1'b0);
        if (win == 0) begin
            chk({tag, "/nogrant"}, 2'b00, 1'b0, 1'b0, m_occ);
            return;
        end
        chk({tag, "/grant"}, 2'b01, win == 1, win == 2, m_occ);
        m_last = win;
        for (int i = 1; i < TRV; i++) begin
            tick(junk(), junk(), 1'b0);
            chk({tag, "/raise"}, 2'b01, 1'b0, 1'b0, m_occ);
        end
        tick(junk(), junk(), 1'b0);
        chk({tag, "/open"}, 2'b10, 1'b0, 1'b0, m_occ);
        open_len = (k < PT) ? k + m + 1 : PT;
        for (int i = 0; i < open_len; i++) begin
            c = (k < PT) && (i >= k) && (i < k + m);
            tick(junk(), junk(), c);
            if (i < open_len - 1) chk({tag, "/wait"}, 2'b10, 1'b0, 1'b0, m_occ);
            else                  chk({tag, "/pass"}, 2'b11, 1'b0, 1'b0, occ_after);
        end
        for (int i = 0; i < TRV; i++) begin
            tick(junk(), junk(), 1'b0);
            chk({tag, "/lower"}, (i < TRV - 1) ? 2'b11 : 2'b00, 1'b0, 1'b0, occ_after);
        end
        m_occ = occ_after;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic er, xr, ee, ex;
        int   k, m, win, occ_after;

        tbl[0] = '{1'b0, 1'b1, 0,  1, 0, 0};
        tbl[1] = '{1'b1, 1'b0, 0,  3, 1, 1};
        tbl[2] = '{1'b1, 1'b0, 2,  1, 1, 2};
        tbl[3] = '{1'b1, 1'b0, 1,  2, 1, 3};
        tbl[4] = '{1'b1, 1'b1, 0,  1, 2, 2};
        tbl[5] = '{1'b1, 1'b1, 3,  1, 1, 3};
        tbl[6] = '{1'b0, 1'b1, PT, 0, 2, 3};
        tbl[7] = '{1'b1, 1'b1, 5,  2, 1, 4};
        tbl[8] = '{1'b0, 1'b1, 15, 1, 2, 3};
        tbl[9] = '{1'b0, 1'b0, 0,  1, 0, 3};

        R = 1'b0; entry_req = 1'b0; exit_req = 1'b0; C = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset", 2'b00, 1'b0, 1'b0, 0);
        R = 1'b1;

        for (int i = 0; i < 10; i++) begin
            txn(tbl[i].er, tbl[i].xr, tbl[i].k, tbl[i].m, tbl[i].win, tbl[i].occ,
                $sformatf("tbl%0d", i));
        end

        // Fill the lot, then a held entry must stay ungranted until an exit completes
        while (m_occ < CAP) txn(1'b1, 1'b0, 0, 1, 1, m_occ + 1, "fill");
        for (int i = 0; i < 20; i++) begin
            tick(1'b1, 1'b0, 1'b0);
            chk("full_hold", 2'b00, 1'b0, 1'b0, CAP);
        end
        txn(1'b1, 1'b1, 0, 1, 2, CAP - 1, "full_exit");
        txn(1'b1, 1'b0, 0, 1, 1, CAP, "full_entry");

        // Timed-out exit, vehicle appears in the 2nd lowering cycle
        tick(1'b0, 1'b1, 1'b0);
        chk("rev/grant", 2'b01, 1'b0, 1'b1, m_occ);
        m_last = 2;
        for (int i = 1; i < TRV; i++) begin
            tick(1'b0, 1'b0, 1'b0);
            chk("rev/raise", 2'b01, 1'b0, 1'b0, m_occ);
        end
        tick(1'b0, 1'b0, 1'b0);
        chk("rev/open", 2'b10, 1'b0, 1'b0, m_occ);
        for (int i = 0; i < PT; i++) begin
            tick(1'b0, 1'b0, 1'b0);
            chk("rev/timeout", (i < PT - 1) ? 2'b10 : 2'b11, 1'b0, 1'b0, m_occ);
        end
        tick(1'b0, 1'b0, 1'b0);
        chk("rev/lower2", 2'b11, 1'b0, 1'b0, m_occ);
        tick(1'b0, 1'b0, 1'b1);
`ifdef GATE_SAFETY_REVERSE_EN
        chk("rev/reverse", 2'b01, 1'b0, 1'b0, m_occ);
        for (int i = 1; i < TRV; i++) begin
            tick(1'b0, 1'b0, 1'b0);
            chk("rev/reraise", 2'b01, 1'b0, 1'b0, m_occ);
        end
        tick(1'b0, 1'b0, 1'b0);
        chk("rev/reopen", 2'b10, 1'b0, 1'b0, m_occ);
        tick(1'b0, 1'b0, 1'b1);
        chk("rev/car", 2'b10, 1'b0, 1'b0, m_occ);
        tick(1'b0, 1'b0, 1'b0);
        m_occ = m_occ - 1;
        chk("rev/pass", 2'b11, 1'b0, 1'b0, m_occ);
        for (int i = 0; i < TRV; i++) begin
            tick(1'b0, 1'b0, 1'b0);
            chk("rev/lower", (i < TRV - 1) ? 2'b11 : 2'b00, 1'b0, 1'b0, m_occ);
        end
`else
        chk("rev/ignored", 2'b11, 1'b0, 1'b0, m_occ);
        for (int j = 3; j <= TRV; j++) begin
            tick(1'b0, 1'b0, 1'b0);
            chk("rev/lower", (j < TRV) ? 2'b11 : 2'b00, 1'b0, 1'b0, m_occ);
        end
`endif

        // Random transactions against the lane/occupancy rules
        for (int n = 0; n < 60; n++) begin
            er = junk();
            xr = junk();
            k  = $urandom_range(0, PT + 2);
            m  = $urandom_range(1, 4);
            ee = er && (m_occ != CAP);
            ex = xr && (m_occ != 0);
            if (!ee && !ex)     win = 0;
            else if (ee && ex)  win = (m_last == 1) ? 2 : 1;
            else                win = ee ? 1 : 2;
            occ_after = m_occ;
            if (win != 0 && k < PT) occ_after = (win == 1) ? m_occ + 1 : m_occ - 1;
            txn(er, xr, k, m, win, occ_after, "rnd");
        end

        // Asynchronous reset while the barrier is open
        er = (m_occ != CAP);
        tick(er, !er, 1'b0);
        chk("rstmid/grant", 2'b01, er, !er, m_occ);
        for (int i = 0; i < TRV + 2; i++) tick(1'b0, 1'b0, 1'b0);
        chk("rstmid/open", 2'b10, 1'b0, 1'b0, m_occ);
        #2 R = 1'b0;
        #1 chk("rstmid/async", 2'b00, 1'b0, 1'b0, 0);
        @(negedge clk);
        R = 1'b1;
        m_occ = 0;
        m_last = 1;
        txn(1'b1, 1'b1, 0, 1, 1, 1, "post_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
